// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths and fetch-state encoding for the fetch path
package cpu_pkg;

    localparam int unsigned PC_W    = 16;
    localparam int unsigned INSTR_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with occupancy count and synchronous flush
module sync_fifo #(
    parameter int unsigned WIDTH = 48,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW:0]       count_q;

    // Flush resets occupancy only; stale storage stays hidden behind count==0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - instruction prefetch FSM feeding a small queue
module instr_fetch_queue
    import cpu_pkg::*;
#(
    parameter int unsigned      DEPTH    = 4,
    parameter logic [PC_W-1:0]  RESET_PC = 16'h0000
) (
    input  logic                clk,
    input  logic                rst,
    output logic                mem_req,
    output logic [PC_W-1:0]     mem_addr,
    input  logic                mem_ack,
    input  logic [INSTR_W-1:0]  mem_rdata,
    input  logic                redirect,
    input  logic [PC_W-1:0]     redirect_pc,
    output logic                instr_valid,
    input  logic                instr_ready,
    output logic [INSTR_W-1:0]  instr_word,
    output logic [PC_W-1:0]     instr_pc
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fetch_state_e                state_q, state_d;
    logic [PC_W-1:0]             fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0]             drain_addr_q, drain_addr_d;
    logic [CW-1:0]               count;
    logic                        push, pop;
    logic [INSTR_W+PC_W-1:0]     head;

    assign pop         = instr_valid & instr_ready;
    assign push        = (state_q == REQ) & mem_ack & ~redirect;
    assign mem_req     = (state_q != IDLE);
    // While draining, fetch_pc already holds the redirect target; the bus keeps the old address.
    assign mem_addr    = (state_q == DRAIN) ? drain_addr_q : fetch_pc_q;
    assign instr_valid = (count != '0);
    assign instr_word  = head[INSTR_W+PC_W-1:PC_W];
    assign instr_pc    = head[PC_W-1:0];

    sync_fifo #(
        .WIDTH (INSTR_W + PC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .push      (push),
        .push_data ({mem_rdata, fetch_pc_q}),
        .pop       (pop),
        .pop_data  (head),
        .count     (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            fetch_pc_q   <= RESET_PC;
            drain_addr_q <= RESET_PC;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            drain_addr_q <= drain_addr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        drain_addr_d = drain_addr_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc;
        end
        case (state_q)
            IDLE: begin
                if (!redirect && (count < CW'(DEPTH))) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (redirect) begin
                    if (mem_ack) begin
                        state_d = IDLE;
                    end else begin
                        state_d      = DRAIN;
                        drain_addr_d = fetch_pc_q;
                    end
                end else if (mem_ack) begin
                    fetch_pc_d = fetch_pc_q + PC_W'(1);
                    state_d    = ((count + CW'(1) - CW'(pop)) < CW'(DEPTH)) ? REQ : IDLE;
                end
            end
            DRAIN: begin
                if (mem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - self-checking bench for instr_fetch_queue
module tb_instr_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk, rst, mem_ack, redirect, instr_ready;
    logic [31:0] mem_rdata;
    logic [15:0] redirect_pc;
    logic        mem_req, instr_valid;
    logic [15:0] mem_addr, instr_pc;
    logic [31:0] instr_word;

    logic        w_req, w_valid;
    logic [15:0] w_addr, w_pc;
    logic [31:0] w_word;

    int n_vec = 0;
    int n_bad = 0;

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(16'h0000)) u_dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .redirect(redirect),
        .redirect_pc(redirect_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr_word(instr_word), .instr_pc(instr_pc)
    );

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(16'hFFFE)) u_wrap (
        .clk(clk), .rst(rst), .mem_req(w_req), .mem_addr(w_addr),
        .mem_ack(1'b1), .mem_rdata(32'h0), .redirect(1'b0),
        .redirect_pc(16'h0), .instr_valid(w_valid),
        .instr_ready(1'b1), .instr_word(w_word), .instr_pc(w_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic rst; logic ack; logic [31:0] rdata; logic redir; logic [15:0] rpc; logic ready;
        logic e_req; logic [15:0] e_addr; logic e_valid;
        logic chk_head; logic [15:0] e_pc; logic [31:0] e_word;
        logic chk_w; logic e_wvalid; logic [15:0] e_wpc;
    } vec_t;

    typedef struct { logic [15:0] pc; logic [31:0] w; } ent_t;

    // Reference model: queue of fetched entries plus the outstanding-request view.
    ent_t        m_q[$];
    bit          m_busy, m_stale;
    logic [15:0] m_pc, m_held;

    task automatic model_step(input logic r, input logic a, input logic [31:0] d,
                              input logic rd, input logic [15:0] rp, input logic rdy);
        bit room;
        bit acked;
        ent_t e;
        if (r) begin
            m_q = {}; m_busy = 0; m_stale = 0; m_pc = 16'h0000;
        end else if (rd) begin
            acked = m_busy && a;
            m_q = {};
            if (m_busy && !acked) begin
                if (!m_stale) begin
                    m_stale = 1; m_held = m_pc;
                end
            end else begin
                m_busy = 0; m_stale = 0;
            end
            m_pc = rp;
        end else begin
            room = (m_q.size() < DEPTH);
            if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
            if (!m_busy) begin
                m_busy = room;
            end else if (a) begin
                if (m_stale) begin
                    m_stale = 0; m_busy = 0;
                end else begin
                    e.pc = m_pc; e.w = d;
                    m_q.push_back(e);
                    m_pc = m_pc + 16'd1;
                    m_busy = (m_q.size() < DEPTH);
                end
            end
        end
    endtask

    vec_t vecs[18];

    initial begin
        int pushes;
        int seen;
        bit found;

        vecs[0]  = '{1,0,32'h0,0,16'h0,0,        0,16'h0000,0, 1,16'h0000,32'h0,        0,0,16'h0};
        vecs[1]  = '{1,0,32'h0,0,16'h0,0,        0,16'h0000,0, 1,16'h0000,32'h0,        1,0,16'h0};
        vecs[2]  = '{0,1,32'h11110000,0,16'h0,1, 0,16'h0000,0, 1,16'h0000,32'h0,        1,0,16'h0};
        vecs[3]  = '{0,1,32'h11110000,0,16'h0,1, 1,16'h0000,0, 1,16'h0000,32'h0,        1,0,16'h0};
        vecs[4]  = '{0,1,32'h11110001,0,16'h0,1, 1,16'h0001,1, 1,16'h0000,32'h11110000, 1,1,16'hFFFE};
        vecs[5]  = '{0,1,32'h11110002,0,16'h0,1, 1,16'h0002,1, 1,16'h0001,32'h11110001, 1,1,16'hFFFF};
        vecs[6]  = '{0,0,32'h0,1,16'h0100,1,     1,16'h0003,1, 1,16'h0002,32'h11110002, 1,1,16'h0000};
        vecs[7]  = '{0,0,32'h0,0,16'h0,1,        1,16'h0003,0, 0,16'h0,32'h0,           1,1,16'h0001};
        vecs[8]  = '{0,0,32'h0,0,16'h0,1,        1,16'h0003,0, 0,16'h0,32'h0,           0,0,16'h0};
        vecs[9]  = '{0,1,32'hDEAD0003,0,16'h0,1, 1,16'h0003,0, 0,16'h0,32'h0,           0,0,16'h0};
        vecs[10] = '{0,0,32'h0,0,16'h0,1,        0,16'h0100,0, 0,16'h0,32'h0,           0,0,16'h0};
        vecs[11] = '{0,0,32'h0,0,16'h0,1,        1,16'h0100,0, 0,16'h0,32'h0,           0,0,16'h0};
        vecs[12] = '{0,1,32'h22220100,0,16'h0,1, 1,16'h0100,0, 0,16'h0,32'h0,           0,0,16'h0};
        vecs[13] = '{0,0,32'h0,0,16'h0,1,        1,16'h0101,1, 1,16'h0100,32'h22220100, 0,0,16'h0};
        vecs[14] = '{0,1,32'hBAD00101,1,16'h0200,1, 1,16'h0101,0, 0,16'h0,32'h0,        0,0,16'h0};
        vecs[15] = '{0,0,32'h0,0,16'h0,1,        0,16'h0200,0, 0,16'h0,32'h0,           0,0,16'h0};
        vecs[16] = '{0,1,32'h33330200,0,16'h0,1, 1,16'h0200,0, 0,16'h0,32'h0,           0,0,16'h0};
        vecs[17] = '{0,0,32'h0,0,16'h0,0,        1,16'h0201,1, 1,16'h0200,32'h33330200, 0,0,16'h0};

        rst = 1; mem_ack = 0; mem_rdata = 0; redirect = 0; redirect_pc = 0; instr_ready = 0;
        @(negedge clk);

        foreach (vecs[i]) begin
            rst = vecs[i].rst; mem_ack = vecs[i].ack; mem_rdata = vecs[i].rdata;
            redirect = vecs[i].redir; redirect_pc = vecs[i].rpc; instr_ready = vecs[i].ready;
            #2;
            chk($sformatf("vec%0d mem_req", i), 32'(mem_req), 32'(vecs[i].e_req));
            chk($sformatf("vec%0d mem_addr", i), 32'(mem_addr), 32'(vecs[i].e_addr));
            chk($sformatf("vec%0d instr_valid", i), 32'(instr_valid), 32'(vecs[i].e_valid));
            if (vecs[i].chk_head) begin
                chk($sformatf("vec%0d instr_pc", i), 32'(instr_pc), 32'(vecs[i].e_pc));
                chk($sformatf("vec%0d instr_word", i), instr_word, vecs[i].e_word);
            end
            if (vecs[i].chk_w) begin
                chk($sformatf("vec%0d wrap valid", i), 32'(w_valid), 32'(vecs[i].e_wvalid));
                if (vecs[i].e_wvalid)
                    chk($sformatf("vec%0d wrap pc", i), 32'(w_pc), 32'(vecs[i].e_wpc));
            end
            @(negedge clk);
        end

        // Full queue with a stalled consumer, then a single pop restarts at address 4.
        rst = 1; mem_ack = 0; instr_ready = 0; redirect = 0;
        @(negedge clk);
        rst = 0; mem_ack = 1; mem_rdata = 32'hC0DE0000;
        pushes = 0;
        for (int c = 0; c < 12; c++) begin
            #2;
            if (mem_req) pushes++;
            @(negedge clk);
        end
        chk("full push count", pushes, 4);
        #2;
        chk("full mem_req", 32'(mem_req), 0);
        chk("full instr_valid", 32'(instr_valid), 1);
        chk("full head pc", 32'(instr_pc), 0);
        instr_ready = 1;
        @(negedge clk);
        instr_ready = 0;
        found = 0;
        for (int c = 0; c < 6 && !found; c++) begin
            #2;
            if (mem_req) found = 1;
            else @(negedge clk);
        end
        chk("restart mem_req rise", 32'(found), 1);
        chk("restart mem_addr", 32'(mem_addr), 16'h0004);
        @(negedge clk);
        mem_ack = 0; instr_ready = 1;
        for (int k = 1; k <= 4; k++) begin
            #2;
            chk($sformatf("drain valid %0d", k), 32'(instr_valid), 1);
            chk($sformatf("drain pc %0d", k), 32'(instr_pc), 32'(k));
            @(negedge clk);
        end
        instr_ready = 0;

        // Reset while three entries are queued and a request is pending.
        rst = 1; mem_ack = 0;
        @(negedge clk);
        rst = 0;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            mem_ack = (seen < 3);
            #2;
            if (mem_req && mem_ack) seen++;
            @(negedge clk);
        end
        mem_ack = 0;
        #2;
        chk("pre-reset mem_req", 32'(mem_req), 1);
        chk("pre-reset instr_valid", 32'(instr_valid), 1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        #2;
        chk("post-reset mem_req", 32'(mem_req), 0);
        chk("post-reset instr_valid", 32'(instr_valid), 0);
        chk("post-reset mem_addr", 32'(mem_addr), 0);
        chk("post-reset instr_word", instr_word, 0);
        mem_ack = 1; instr_ready = 1;
        @(negedge clk);
        found = 0;
        for (int c = 0; c < 4 && !found; c++) begin
            #2;
            if (mem_req) found = 1;
            else @(negedge clk);
        end
        chk("post-reset restart", 32'(found), 1);
        chk("post-reset restart addr", 32'(mem_addr), 0);
        @(negedge clk);

        // Randomized traffic against the reference model.
        rst = 1; mem_ack = 0; redirect = 0; instr_ready = 0;
        model_step(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        for (int c = 0; c < 800; c++) begin
            rst         = ($urandom_range(0, 99) == 0);
            mem_ack     = m_busy && ($urandom_range(0, 2) != 0);
            mem_rdata   = $urandom;
            redirect    = ($urandom_range(0, 15) == 0);
            redirect_pc = 16'($urandom);
            instr_ready = ($urandom_range(0, 3) != 0);
            #2;
            chk("rand mem_req", 32'(mem_req), 32'(m_busy));
            chk("rand mem_addr", 32'(mem_addr), 32'(m_stale ? m_held : m_pc));
            chk("rand instr_valid", 32'(instr_valid), 32'(m_q.size() != 0));
            if (m_q.size() != 0) begin
                chk("rand instr_pc", 32'(instr_pc), 32'(m_q[0].pc));
                chk("rand instr_word", instr_word, m_q[0].w);
            end
            model_step(rst, mem_ack, mem_rdata, redirect, redirect_pc, instr_ready);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
